// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR controller and its read clients.
package ddr_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/line_buffer_ram.sv
// Ping-pong scanline store: one write port, one registered read port.
// The bank select is carried as the address MSB by the caller.
module line_buffer_ram #(
  parameter int unsigned AddrW = 9,
  parameter int unsigned DataW = 32
) (
  input  logic             clk133_p,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [DataW-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [DataW-1:0] rd_data
);

  logic [DataW-1:0] mem_q [(1 << AddrW)];
  logic [DataW-1:0] rd_data_q;

  always_ff @(posedge clk133_p) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk133_p) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/scanline_fetcher.sv
// Prefetches framebuffer scanlines from DDR into a ping-pong line buffer.
// Define LINE_DOUBLE_EN to show each fetched line on two display lines.
module scanline_fetcher
  import ddr_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 160,
  parameter int unsigned LINES          = 480,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned ADDR_W         = ddr_pkg::ADDR_W
) (
  input  logic              clk133_p,
  input  logic              rst,
  input  logic              frameStart,
  input  logic              lineStart,
  output logic              rdReq,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic              rdAck,
  input  logic              rdValid,
  input  logic [WORD_W-1:0] rdData,
  input  logic [7:0]        pixAddr,
  output logic [WORD_W-1:0] pixData,
  output logic              underrun
);

  localparam int unsigned IdxW  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int unsigned CntW  = IdxW + 1;
  localparam int unsigned LineW = $clog2(LINES + 1);
  localparam logic [CntW-1:0]   LastWord  = CntW'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] BaseAddr  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LineWords = ADDR_W'(WORDS_PER_LINE);

  fetch_state_e      state_q;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [CntW-1:0]   word_cnt_q;
  logic [LineW-1:0]  line_idx_q;
  logic              disp_bank_q;
  logic              underrun_q;

  logic              line_evt;
  logic              accept;
  logic              pending;
  logic              more_lines;
  logic              wr_en;
  logic              req_hold;
  logic [ADDR_W-1:0] next_line_addr;
  logic              unused_pix;

`ifdef LINE_DOUBLE_EN
  logic parity_q;

  always_ff @(posedge clk133_p) begin
    if (rst || frameStart) begin
      parity_q <= 1'b0;
    end else if (lineStart) begin
      parity_q <= ~parity_q;
    end
  end

  // Odd-parity lines repeat the previous line: no swap, no fetch.
  assign line_evt = lineStart && !frameStart && !parity_q;
`else
  assign line_evt = lineStart && !frameStart;
`endif

  assign accept         = (state_q == StReq) && rd_req_q && rdAck;
  // A read is still in flight after this edge.
  assign pending        = accept || (((state_q == StWait) || (state_q == StDrain)) && !rdValid);
  assign more_lines     = 32'(line_idx_q) < LINES;
  assign wr_en          = (state_q == StWait) && rdValid && !frameStart && !line_evt;
  assign req_hold       = (state_q == StReq) && !accept && !frameStart && !line_evt;
  assign next_line_addr = addr_cnt_q - ADDR_W'(word_cnt_q) + LineWords;
  assign unused_pix     = ^pixAddr;

  always_ff @(posedge clk133_p) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      addr_cnt_q  <= BaseAddr;
      word_cnt_q  <= '0;
      line_idx_q  <= '0;
      disp_bank_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // Address only changes while the request is low, so it is stable under rdReq.
      rd_req_q <= req_hold;
      if (req_hold && !rd_req_q) begin
        rd_addr_q <= addr_cnt_q;
      end

      if (frameStart) begin
        line_idx_q <= '0;
        word_cnt_q <= '0;
        underrun_q <= 1'b0;
        addr_cnt_q <= BaseAddr;
        state_q    <= pending ? StDrain : StReq;
      end else if (line_evt) begin
        disp_bank_q <= ~disp_bank_q;
        word_cnt_q  <= '0;
        if (state_q == StIdle) begin
          if (more_lines) begin
            state_q <= StReq;
          end
        end else begin
          // Late line is abandoned; skip to the next one to keep addresses in step.
          underrun_q <= 1'b1;
          addr_cnt_q <= next_line_addr;
          line_idx_q <= line_idx_q + LineW'(1);
          state_q    <= pending ? StDrain : StReq;
        end
      end else begin
        unique case (state_q)
          StIdle: ;
          StReq: begin
            if (accept) begin
              state_q <= StWait;
            end
          end
          StWait: begin
            if (rdValid) begin
              word_cnt_q <= word_cnt_q + CntW'(1);
              addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
              if (word_cnt_q == LastWord) begin
                line_idx_q <= line_idx_q + LineW'(1);
                state_q    <= StIdle;
              end else begin
                state_q <= StReq;
              end
            end
          end
          StDrain: begin
            if (rdValid) begin
              state_q <= StReq;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  line_buffer_ram #(
    .AddrW(IdxW + 1),
    .DataW(WORD_W)
  ) u_line_buffer_ram (
    .clk133_p(clk133_p),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({~disp_bank_q, word_cnt_q[IdxW-1:0]}),
    .wr_data (rdData),
    .rd_addr ({disp_bank_q, pixAddr[IdxW-1:0]}),
    .rd_data (pixData)
  );

  assign rdReq    = rd_req_q;
  assign rdAddr   = rd_addr_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_scanline_fetcher.sv
// Scoreboard bench for scanline_fetcher with a 2-cycle-ack / 4-cycle-valid DDR model.
module tb_scanline_fetcher;

  logic        clk133_p = 1'b0;
  logic        rst = 1'b1;
  logic        frameStart = 1'b0;
  logic        lineStart = 1'b0;
  logic        rdReq;
  logic [23:0] rdAddr;
  logic        rdAck;
  logic        rdValid;
  logic [31:0] rdData;
  logic [7:0]  pixAddr = '0;
  logic [31:0] pixData;
  logic        underrun;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  logic stall = 1'b0;
  logic pix_strobe = 1'b0;
  logic [23:0] exp_addr_q [$];
  logic [31:0] exp_pix_q [$];

  int m_phase = 0;
  int m_cnt = 0;
  logic [23:0] m_lat = '0;

  scanline_fetcher #(
    .WORDS_PER_LINE(4),
    .LINES         (2),
    .BASE_ADDR     (0),
    .ADDR_W        (24)
  ) dut (
    .clk133_p  (clk133_p),
    .rst       (rst),
    .frameStart(frameStart),
    .lineStart (lineStart),
    .rdReq     (rdReq),
    .rdAddr    (rdAddr),
    .rdAck     (rdAck),
    .rdValid   (rdValid),
    .rdData    (rdData),
    .pixAddr   (pixAddr),
    .pixData   (pixData),
    .underrun  (underrun)
  );

  always #5 clk133_p = ~clk133_p;

  function automatic logic [31:0] ddr_word(input logic [23:0] a);
    return 32'hC0DE_0000 | {8'h00, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // DDR controller model: ack two cycles into a request, data four cycles after ack.
  initial begin
    rdAck = 1'b0;
    rdValid = 1'b0;
    rdData = '0;
    forever begin
      @(negedge clk133_p);
      rdAck = 1'b0;
      rdValid = 1'b0;
      if (rst) begin
        m_phase = 0;
        m_cnt = 0;
      end else if (m_phase == 0) begin
        if (rdReq) begin
          m_cnt++;
          if (m_cnt == 2) begin
            rdAck = 1'b1;
            m_lat = rdAddr;
            m_phase = 1;
            m_cnt = 0;
          end
        end else begin
          m_cnt = 0;
        end
      end else if (!stall) begin
        m_cnt++;
        if (m_cnt == 4) begin
          rdValid = 1'b1;
          rdData = ddr_word(m_lat);
          valid_cnt++;
          m_phase = 0;
          m_cnt = 0;
        end
      end
    end
  end

  // Request monitor: each accepted request must carry the next expected address.
  initial begin
    forever begin
      @(posedge clk133_p);
      #1;
      if (rdAck) begin
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rdAddr: unexpected request at %h, none expected", rdAddr);
        end else begin
          check("rdAddr", 32'(rdAddr), 32'(exp_addr_q.pop_front()));
        end
      end
    end
  end

  // Pixel monitor: pixData one cycle after pixAddr is presented.
  initial begin
    forever begin
      @(posedge clk133_p);
      #1;
      if (pix_strobe) begin
        if (exp_pix_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pixData: read with empty queue, got %h", pixData);
        end else begin
          check("pixData", pixData, exp_pix_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic fs, input logic ls);
    @(negedge clk133_p);
    frameStart = fs;
    lineStart = ls;
    @(negedge clk133_p);
    frameStart = 1'b0;
    lineStart = 1'b0;
  endtask

  task automatic push_line(input int first);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(24'(first + i));
  endtask

  task automatic pix_read(input int idx, input logic [31:0] exp);
    @(negedge clk133_p);
    pixAddr = 8'(idx);
    exp_pix_q.push_back(exp);
    pix_strobe = 1'b1;
    @(negedge clk133_p);
    pix_strobe = 1'b0;
  endtask

  task automatic wait_valids(input int target, input string name);
    int n = 0;
    while (valid_cnt < target && n < 200) begin
      @(negedge clk133_p);
      n++;
    end
    check(name, 32'(valid_cnt), 32'(target));
    repeat (2) @(negedge clk133_p);
  endtask

  task automatic no_req_for(input int cycles, input string name);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk133_p);
      if (rdReq) hits++;
    end
    check(name, 32'(hits), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk133_p);
    check("reset rdReq", 32'(rdReq), 32'd0);
    check("reset rdAddr", 32'(rdAddr), 32'd0);
    check("reset pixData", pixData, 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    @(negedge clk133_p);

`ifdef LINE_DOUBLE_EN
    push_line(0);
    pulse(1'b1, 1'b0);
    wait_valids(4, "dbl line0 fetched");
    push_line(4);
    pulse(1'b0, 1'b1);
    pix_read(2, ddr_word(24'd2));
    wait_valids(8, "dbl line1 fetched");
    pulse(1'b0, 1'b1);
    pix_read(2, ddr_word(24'd2));
    no_req_for(10, "dbl odd lineStart fetch");
    pulse(1'b0, 1'b1);
    pix_read(2, ddr_word(24'd6));
    pulse(1'b0, 1'b1);
    pix_read(2, ddr_word(24'd6));
    no_req_for(10, "dbl end of frame fetch");
    check("dbl fetch count", 32'(valid_cnt), 32'd8);
    check("dbl underrun", 32'(underrun), 32'd0);
`else
    // Line 0 after frameStart, then line 1 while line 0 is displayed.
    push_line(0);
    pulse(1'b1, 1'b0);
    wait_valids(4, "line0 fetched");
    check("fsm idle after line", 32'(dut.state_q), 32'(ddr_pkg::StIdle));
    no_req_for(5, "idle no request");
    push_line(4);
    pulse(1'b0, 1'b1);
    pix_read(2, ddr_word(24'd2));
    pix_read(0, ddr_word(24'd0));
    pix_read(3, ddr_word(24'd3));
    wait_valids(8, "line1 fetched");
    pix_read(1, ddr_word(24'd1));
    // lineIdx has reached LINES: swap only.
    pulse(1'b0, 1'b1);
    no_req_for(20, "frame end no fetch");
    pix_read(0, ddr_word(24'd4));
    pix_read(3, ddr_word(24'd7));
    pulse(1'b0, 1'b1);
    no_req_for(20, "third lineStart no fetch");
    pix_read(2, ddr_word(24'd2));

    // Underrun: controller stalls mid-line, lineStart arrives in WAIT.
    push_line(0);
    pulse(1'b1, 1'b0);
    wait_valids(12, "frame2 line0 fetched");
    stall = 1'b1;
    exp_addr_q.push_back(24'd4);
    pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk133_p);
    check("underrun before", 32'(underrun), 32'd0);
    pulse(1'b0, 1'b1);
    check("underrun set", 32'(underrun), 32'd1);
    push_line(8);
    stall = 1'b0;
    wait_valids(13, "late word returned");
    pix_read(0, ddr_word(24'd0));
    wait_valids(17, "line2 fetched");
    check("underrun sticky", 32'(underrun), 32'd1);
    push_line(0);
    pulse(1'b1, 1'b0);
    check("underrun cleared", 32'(underrun), 32'd0);
    wait_valids(21, "frame3 line0 fetched");

    // frameStart wins over a simultaneous lineStart; display bank is untouched.
    push_line(4);
    pulse(1'b0, 1'b1);
    wait_valids(25, "frame3 line1 fetched");
    push_line(0);
    pulse(1'b1, 1'b1);
    pix_read(1, ddr_word(24'd1));
    wait_valids(29, "restart line0 fetched");
    check("fsm idle after restart", 32'(dut.state_q), 32'(ddr_pkg::StIdle));
    pix_read(3, ddr_word(24'd3));
`endif

    repeat (4) @(negedge clk133_p);
    check("addr queue drained", 32'(exp_addr_q.size()), 32'd0);
    check("pix queue drained", 32'(exp_pix_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scanline_fetcher.md
# scanline_fetcher

Fetches one scanline of framebuffer words from the DDR controller ahead of display. It stores each line in a ping-pong line buffer so the VGA pixel pipeline can read the current line while the next one fills. It sits between the DDR controller's read port (upstream, 32-bit read words) and the VGA pixel serializer (downstream, random-access word reads). Everything runs in the 133 MHz controller clock domain.

## Interface
Parameters:
- WORDS_PER_LINE, 160: 32-bit words per scanline (640 px at 8 bpp).
- LINES, 480: lines per frame.
- BASE_ADDR, 0: word address of line 0, word 0.
- ADDR_W, 24: DDR word-address width.

Ports:
- clk133_p  in  1  controller clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- frameStart  in  1  one-cycle pulse that restarts the fetch at line 0.
- lineStart  in  1  one-cycle pulse at the start of each displayed line; swaps the buffer banks.
- rdReq  out  1  read request to the DDR controller.
- rdAddr  out  ADDR_W  word address; held stable while rdReq is high.
- rdAck  in  1  controller accepted the request (sampled while rdReq is high).
- rdValid  in  1  one-cycle strobe; rdData is valid.
- rdData  in  32  returned word.
- pixAddr  in  8  word index (0..WORDS_PER_LINE-1) into the display bank.
- pixData  out  32  display-bank word, registered.
- underrun  out  1  sticky error flag; cleared by frameStart or rst.

## Operation
- There are two banks of WORDS_PER_LINE × 32 bits. `dispBank` is read by pixAddr; the other bank is the fill bank.
- FSM states:
  - IDLE → REQ on frameStart, or on lineStart when lineIdx < LINES.
  - REQ: hold rdReq=1 and rdAddr. On rdAck go to WAIT.
  - WAIT: on rdValid, write rdData to fill[wordCnt], increment wordCnt and addrCnt. If wordCnt was WORDS_PER_LINE-1, go to IDLE with lineIdx+1. Otherwise go to REQ.
  - DRAIN: wait for the outstanding rdValid, discard the data, then go to REQ for the new line.
- Only one request is outstanding at a time.
- Address arithmetic: addrCnt is ADDR_W bits and starts at BASE_ADDR on frameStart. It increments once per accepted word and is never recomputed from lineIdx, so consecutive lines are contiguous. It wraps modulo 2^ADDR_W.
- lineStart with the FSM in IDLE:
  - Toggle dispBank and clear wordCnt.
  - If lineIdx < LINES, go to REQ.
  - If lineIdx ≥ LINES, only swap; do not fetch.
- lineStart while in REQ: swap banks, set underrun, clear wordCnt, and advance addrCnt to the start of the next line. Stay in REQ.
- lineStart while in WAIT: same as REQ, except go to DRAIN.
- frameStart:
  - Clear lineIdx, wordCnt and underrun; set addrCnt to BASE_ADDR.
  - Go to REQ, or to DRAIN if a read is outstanding.
  - dispBank is unchanged.
- frameStart and lineStart in the same cycle: frameStart wins and lineStart is ignored.
- rdValid outside WAIT/DRAIN is ignored.
- Reset values: rdReq=0, rdAddr=0, pixData=0, underrun=0, dispBank=0, lineIdx=0, wordCnt=0, addrCnt=BASE_ADDR, FSM=IDLE.

## Timing
- rdReq rises the cycle after entering REQ and falls the cycle after rdAck is sampled high.
- Next request: rdReq reasserts one cycle after the rdValid that completes the previous word.
- Buffer write: the bank write happens on the same edge that samples rdValid.
- pixData latency: one cycle from pixAddr (synchronous RAM read). The bank swap takes effect for the pixAddr sampled on the cycle after lineStart.
- Reset mid-operation: rst drops rdReq on the next edge, and any read returned afterwards is ignored. The controller must be reset together with this block.

## Configuration
- LINE_DOUBLE_EN defined:
  - Each source line is displayed twice and LINES counts source lines (display = 2×LINES).
  - An internal parity bit toggles on each lineStart.
  - On even-parity lineStart: swap banks and fetch.
  - On odd-parity lineStart: no swap, no fetch, no underrun check.
  - frameStart clears parity.
- LINE_DOUBLE_EN undefined: every lineStart swaps banks; there is no parity logic.

## Structure
- Package ddr_pkg holds ADDR_W, the word width (32), and the fetch-FSM state enum (IDLE, REQ, WAIT, DRAIN). The controller and this block share the package.
- Sub-module line_buffer_ram: one write port, one registered read port, bank select as the address MSB. It is instantiated once (2×WORDS_PER_LINE deep).

## Test plan
- Reset, then frameStart with a 2-cycle-ack / 4-cycle-valid controller model, WORDS_PER_LINE=4 → rdAddr 0,1,2,3 in order, FSM IDLE; after lineStart, pixAddr=2 returns the word from address 2.
- Two lines back-to-back → second fetch uses addresses 4..7 and fills the opposite bank; display shows line 0 words while line 1 fills.
- lineStart while in WAIT (controller stalled) → underrun=1, late rdValid discarded, next request address = start of the following line; frameStart clears underrun.
- frameStart and lineStart in the same cycle → addrCnt=BASE_ADDR, dispBank unchanged.
- LINES=2: third lineStart → swap only, no rdReq.
- LINE_DOUBLE_EN: 4 lineStarts → 2 fetches, dispBank toggles twice, identical pixData on paired lines.
